// File: rtl/fsab_initiator_pkg.sv
// Shared FSAB bus widths, encodings and credit constants for the initiator slice.
// Also carries the held request header type and a length legality helper.
package fsab_initiator_pkg;

    localparam int FSAB_REQ_HI     = 0;
    localparam int FSAB_DID_HI     = 3;
    localparam int FSAB_ADDR_HI    = 30;
    localparam int FSAB_LEN_HI     = 3;
    localparam int FSAB_DATA_HI    = 63;
    localparam int FSAB_MASK_HI    = 7;
    localparam int FSAB_CREDITS_HI = 2;
    localparam int FSAB_LEN_MAX    = 8;

    localparam logic [FSAB_CREDITS_HI:0] FSAB_INITIAL_CREDITS = 3'd4;
    localparam logic [FSAB_REQ_HI:0]     FSAB_READ            = 1'b0;
    localparam logic [FSAB_REQ_HI:0]     FSAB_WRITE           = 1'b1;

    typedef logic [FSAB_LEN_HI:0] fsab_len_t;

    typedef struct packed {
        logic [FSAB_REQ_HI:0]  mode;
        logic [FSAB_ADDR_HI:0] addr;
        fsab_len_t             len;
    } fsab_hdr_t;

    // Zero-length and over-long bursts are both dropped as illegal.
    function automatic logic fsab_len_legal(input fsab_len_t len);
        return (len != '0) && (len <= fsab_len_t'(FSAB_LEN_MAX));
    endfunction

endpackage

// File: rtl/fsab_len_fifo.sv
// Synchronous FIFO holding the burst lengths of outstanding reads.
// Push and pop in the same cycle are both honoured; overflow/underflow requests are ignored.
module fsab_len_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;
    logic             pushOk;
    logic             popOk;

    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);
    assign dout   = mem_q[rdPtr_q];
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= din;
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            if (pushOk && !popOk) begin
                count_q <= count_q + (PW + 1)'(1);
            end else if (popOk && !pushOk) begin
                count_q <= count_q - (PW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/fsab_initiator.sv
// FSAB bus master: turns client requests/write beats into credited fsabo beats
// and returns fsabi read beats for this DID to the client with a last flag.
module fsab_initiator
    import fsab_initiator_pkg::*;
#(
    parameter logic [FSAB_DID_HI:0] DID       = '0,
    parameter logic [FSAB_DID_HI:0] SUBDID    = '0,
    parameter int                   RDQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [FSAB_ADDR_HI:0] req_addr,
    input  logic [FSAB_LEN_HI:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [FSAB_DATA_HI:0] wr_data,
    input  logic [FSAB_MASK_HI:0] wr_mask,
    output logic                  fsabo_valid,
    output logic [FSAB_REQ_HI:0]  fsabo_mode,
    output logic [FSAB_DID_HI:0]  fsabo_did,
    output logic [FSAB_DID_HI:0]  fsabo_subdid,
    output logic [FSAB_ADDR_HI:0] fsabo_addr,
    output logic [FSAB_LEN_HI:0]  fsabo_len,
    output logic [FSAB_DATA_HI:0] fsabo_data,
    output logic [FSAB_MASK_HI:0] fsabo_mask,
    input  logic                  fsabo_credit,
    input  logic                  fsabi_valid,
    input  logic [FSAB_DID_HI:0]  fsabi_did,
    input  logic [FSAB_DATA_HI:0] fsabi_data,
    output logic                  rd_valid,
    output logic [FSAB_DATA_HI:0] rd_data,
    output logic                  rd_last,
    output logic                  err
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WDATA = 1'b1;

    logic                     state_q,      state_d;
    logic [FSAB_CREDITS_HI:0] credits_q,    credits_d;
    fsab_len_t                rem_q,        rem_d;
    fsab_len_t                cnt_q,        cnt_d;
    logic                     err_q,        err_d;
    fsab_hdr_t                hdr_q,        hdr_d;
    logic                     busValid_q,   busValid_d;
    logic [FSAB_DATA_HI:0]    busData_q,    busData_d;
    logic [FSAB_MASK_HI:0]    busMask_q,    busMask_d;
    logic                     rdValid_q,    rdValid_d;
    logic [FSAB_DATA_HI:0]    rdData_q,     rdData_d;
    logic                     rdLast_q,     rdLast_d;

    logic      lenLegal;
    logic      acceptRead;
    logic      acceptWrite;
    logic      dropReq;
    logic      consume;
    logic      creditOverflow;
    logic      rdBeat;
    logic      rdTake;
    logic      rdEnd;
    logic      rdOrphan;
    logic      rdqFull;
    logic      rdqEmpty;
    fsab_len_t rdqHead;

    assign lenLegal = fsab_len_legal(req_len);
    assign consume  = acceptRead || acceptWrite;

    fsab_len_fifo #(
        .WIDTH (FSAB_LEN_HI + 1),
        .DEPTH (RDQ_DEPTH)
    ) u_rdq (
        .clk   (clk),
        .rst   (rst),
        .push  (acceptRead),
        .pop   (rdEnd),
        .din   (req_len),
        .dout  (rdqHead),
        .full  (rdqFull),
        .empty (rdqEmpty)
    );

    // Request handshake: illegal lengths are swallowed without a credit or a bus beat.
    always_comb begin
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        acceptRead  = 1'b0;
        acceptWrite = 1'b0;
        dropReq     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req_valid && !lenLegal) begin
                req_ready = 1'b1;
                dropReq   = 1'b1;
            end else if (req_valid && (credits_q != '0) &&
                         (req_write ? wr_valid : !rdqFull)) begin
                req_ready = 1'b1;
                if (req_write) begin
                    acceptWrite = 1'b1;
                    wr_ready    = 1'b1;
                end else begin
                    acceptRead = 1'b1;
                end
            end
        end else begin
            wr_ready = wr_valid;
        end
    end

    // Bus beat generation; the header stays put across write data beats and gaps.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        hdr_d      = hdr_q;
        busValid_d = 1'b0;
        busData_d  = '0;
        busMask_d  = '0;
        if (acceptRead) begin
            busValid_d = 1'b1;
            hdr_d.mode = FSAB_READ;
            hdr_d.addr = req_addr;
            hdr_d.len  = req_len;
        end else if (acceptWrite) begin
            busValid_d = 1'b1;
            busData_d  = wr_data;
            busMask_d  = wr_mask;
            hdr_d.mode = FSAB_WRITE;
            hdr_d.addr = req_addr;
            hdr_d.len  = req_len;
            rem_d      = req_len - fsab_len_t'(1);
            if (req_len != fsab_len_t'(1)) begin
                state_d = ST_WDATA;
            end
        end else if ((state_q == ST_WDATA) && wr_valid) begin
            busValid_d = 1'b1;
            busData_d  = wr_data;
            busMask_d  = wr_mask;
            rem_d      = rem_q - fsab_len_t'(1);
            if (rem_q == fsab_len_t'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Credit pool saturates at its initial size; an extra return is a responder bug.
    always_comb begin
        credits_d      = credits_q;
        creditOverflow = 1'b0;
        if (consume && !fsabo_credit) begin
            credits_d = credits_q - FSAB_CREDITS_HI'(1) - 1'b0;
        end else if (!consume && fsabo_credit) begin
            if (credits_q == FSAB_INITIAL_CREDITS) begin
                creditOverflow = 1'b1;
            end else begin
                credits_d = credits_q + (FSAB_CREDITS_HI + 1)'(1);
            end
        end
    end

    assign rdBeat   = fsabi_valid && (fsabi_did == DID);
    assign rdTake   = rdBeat && !rdqEmpty;
    assign rdEnd    = rdTake && (cnt_q == rdqHead - fsab_len_t'(1));
    assign rdOrphan = rdBeat && rdqEmpty;

    // Return path counts beats against the oldest outstanding read length.
    always_comb begin
        cnt_d     = cnt_q;
        rdValid_d = rdTake;
        rdData_d  = rdTake ? fsabi_data : '0;
        rdLast_d  = rdEnd;
        if (rdEnd) begin
            cnt_d = '0;
        end else if (rdTake) begin
            cnt_d = cnt_q + fsab_len_t'(1);
        end
        err_d = err_q || dropReq || creditOverflow || rdOrphan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            credits_q  <= FSAB_INITIAL_CREDITS;
            rem_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hdr_q      <= '0;
            busValid_q <= 1'b0;
            busData_q  <= '0;
            busMask_q  <= '0;
            rdValid_q  <= 1'b0;
            rdData_q   <= '0;
            rdLast_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            hdr_q      <= hdr_d;
            busValid_q <= busValid_d;
            busData_q  <= busData_d;
            busMask_q  <= busMask_d;
            rdValid_q  <= rdValid_d;
            rdData_q   <= rdData_d;
            rdLast_q   <= rdLast_d;
        end
    end

    assign fsabo_valid  = busValid_q;
    assign fsabo_mode   = hdr_q.mode;
    assign fsabo_did    = DID;
    assign fsabo_subdid = SUBDID;
    assign fsabo_addr   = hdr_q.addr;
    assign fsabo_len    = hdr_q.len;
    assign fsabo_data   = busData_q;
    assign fsabo_mask   = busMask_q;
    assign rd_valid     = rdValid_q;
    assign rd_data      = rdData_q;
    assign rd_last      = rdLast_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fsab_initiator.sv
// Self-checking bench for fsab_initiator: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the bus master.
module tb_fsab_initiator;
    import fsab_initiator_pkg::*;

    localparam logic [FSAB_DID_HI:0] TB_DID       = 4'd3;
    localparam logic [FSAB_DID_HI:0] TB_SUBDID    = 4'd5;
    localparam logic [FSAB_DID_HI:0] OTHER_DID    = 4'd9;
    localparam int                   TB_RDQ_DEPTH = 8;
    localparam int                   INIT_CREDITS = int'(FSAB_INITIAL_CREDITS);

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [FSAB_ADDR_HI:0] req_addr;
    logic [FSAB_LEN_HI:0]  req_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [FSAB_DATA_HI:0] wr_data;
    logic [FSAB_MASK_HI:0] wr_mask;
    logic                  fsabo_valid;
    logic [FSAB_REQ_HI:0]  fsabo_mode;
    logic [FSAB_DID_HI:0]  fsabo_did;
    logic [FSAB_DID_HI:0]  fsabo_subdid;
    logic [FSAB_ADDR_HI:0] fsabo_addr;
    logic [FSAB_LEN_HI:0]  fsabo_len;
    logic [FSAB_DATA_HI:0] fsabo_data;
    logic [FSAB_MASK_HI:0] fsabo_mask;
    logic                  fsabo_credit;
    logic                  fsabi_valid;
    logic [FSAB_DID_HI:0]  fsabi_did;
    logic [FSAB_DATA_HI:0] fsabi_data;
    logic                  rd_valid;
    logic [FSAB_DATA_HI:0] rd_data;
    logic                  rd_last;
    logic                  err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state: plain integers and queues.
    int                    credits;
    int                    rdq[$];
    int                    beatCnt;
    bit                    inWrite;
    int                    wrRem;
    bit                    errExp;
    logic [FSAB_REQ_HI:0]  expMode;
    logic [FSAB_ADDR_HI:0] expAddr;
    logic [FSAB_LEN_HI:0]  expLen;
    int                    pendCred;
    int                    respQ[$];

    fsab_initiator #(
        .DID       (TB_DID),
        .SUBDID    (TB_SUBDID),
        .RDQ_DEPTH (TB_RDQ_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_mask      (wr_mask),
        .fsabo_valid  (fsabo_valid),
        .fsabo_mode   (fsabo_mode),
        .fsabo_did    (fsabo_did),
        .fsabo_subdid (fsabo_subdid),
        .fsabo_addr   (fsabo_addr),
        .fsabo_len    (fsabo_len),
        .fsabo_data   (fsabo_data),
        .fsabo_mask   (fsabo_mask),
        .fsabo_credit (fsabo_credit),
        .fsabi_valid  (fsabi_valid),
        .fsabi_did    (fsabi_did),
        .fsabi_data   (fsabi_data),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idleInputs();
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_len      = '0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        wr_mask      = '0;
        fsabo_credit = 1'b0;
        fsabi_valid  = 1'b0;
        fsabi_did    = '0;
        fsabi_data   = '0;
    endtask

    task automatic modelReset();
        credits  = INIT_CREDITS;
        rdq.delete();
        beatCnt  = 0;
        inWrite  = 1'b0;
        wrRem    = 0;
        errExp   = 1'b0;
        expMode  = '0;
        expAddr  = '0;
        expLen   = '0;
        pendCred = 0;
        respQ.delete();
    endtask

    // Asserts reset away from a clock edge, checks every output drops at once, releases on a negedge.
    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset_outputs",
            {req_ready, wr_ready, fsabo_valid, fsabo_mode, fsabo_addr, fsabo_len,
             fsabo_data, fsabo_mask, rd_valid, rd_data, rd_last, err}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock with the currently driven inputs; predicts and checks handshakes and registered outputs.
    task automatic applyStimulus();
        bit                    legal, acc, accW, expReqRdy, expWrRdy;
        bit                    expFv, rdExpV, rdExpLast;
        logic [FSAB_DATA_HI:0] expData, rdExpData;
        logic [FSAB_MASK_HI:0] expMask;
        int                    junk;
        @(negedge clk);
        legal     = (req_len >= 1) && (int'(req_len) <= FSAB_LEN_MAX);
        expReqRdy = 1'b0;
        expWrRdy  = 1'b0;
        acc       = 1'b0;
        accW      = 1'b0;
        if (!inWrite) begin
            if (req_valid && !legal) begin
                expReqRdy = 1'b1;
                errExp    = 1'b1;
            end else if (req_valid && credits > 0 &&
                         (req_write ? wr_valid : (rdq.size() < TB_RDQ_DEPTH))) begin
                expReqRdy = 1'b1;
                acc       = 1'b1;
                accW      = req_write;
                expWrRdy  = req_write;
            end
        end else begin
            expWrRdy = wr_valid;
        end
        checkOutput("ready", {req_ready, wr_ready}, {expReqRdy, expWrRdy});

        rdExpV    = 1'b0;
        rdExpLast = 1'b0;
        rdExpData = '0;
        if (fsabi_valid && fsabi_did == TB_DID) begin
            if (rdq.size() == 0) begin
                errExp = 1'b1;
            end else begin
                rdExpV    = 1'b1;
                rdExpData = fsabi_data;
                beatCnt++;
                if (beatCnt == rdq[0]) begin
                    rdExpLast = 1'b1;
                    junk      = rdq.pop_front();
                    beatCnt   = 0;
                end
            end
        end

        expFv   = 1'b0;
        expData = '0;
        expMask = '0;
        if (acc) begin
            expFv   = 1'b1;
            expMode = accW ? FSAB_WRITE : FSAB_READ;
            expAddr = req_addr;
            expLen  = req_len;
            if (accW) begin
                expData = wr_data;
                expMask = wr_mask;
                wrRem   = int'(req_len) - 1;
                inWrite = (wrRem != 0);
            end else begin
                rdq.push_back(int'(req_len));
                respQ.push_back(int'(req_len));
            end
        end else if (inWrite && wr_valid) begin
            expFv   = 1'b1;
            expData = wr_data;
            expMask = wr_mask;
            wrRem--;
            inWrite = (wrRem != 0);
        end

        credits = credits - int'(acc) + int'(fsabo_credit);
        if (credits > INIT_CREDITS) begin
            credits = INIT_CREDITS;
            errExp  = 1'b1;
        end
        pendCred = pendCred + int'(acc) - int'(fsabo_credit);

        @(posedge clk);
        #1;
        checkOutput("fsabo_valid", fsabo_valid, expFv);
        if (expFv) begin
            checkOutput("fsabo_hdr", {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len},
                        {expMode, TB_DID, TB_SUBDID, expAddr, expLen});
            checkOutput("fsabo_payload", {fsabo_data, fsabo_mask}, {expData, expMask});
        end
        checkOutput("rd_valid", rd_valid, rdExpV);
        checkOutput("rd_last", rd_last, rdExpLast);
        if (rdExpV) begin
            checkOutput("rd_data", rd_data, rdExpData);
        end
        checkOutput("err", err, errExp);
    endtask

    task automatic sendBeat(input logic [FSAB_DID_HI:0] did, input logic [FSAB_DATA_HI:0] data);
        idleInputs();
        fsabi_valid = 1'b1;
        fsabi_did   = did;
        fsabi_data  = data;
        applyStimulus();
    endtask

    task automatic readReq(input logic [FSAB_ADDR_HI:0] addr, input int len);
        idleInputs();
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = fsab_len_t'(len);
        applyStimulus();
    endtask

    task automatic returnCredits();
        for (int i = 0; i < 16 && pendCred > 0; i++) begin
            idleInputs();
            fsabo_credit = 1'b1;
            applyStimulus();
        end
        idleInputs();
    endtask

    initial begin
        idleInputs();
        modelReset();
        doReset();

        // Read len 4 then four returned beats; last flag only on the fourth.
        readReq(31'h100, 4);
        idleInputs();
        applyStimulus();
        for (int i = 0; i < 4; i++) sendBeat(TB_DID, 64'hD000 + 64'(i));

        // Write len 3 with a data gap after the second beat; a read request waits meanwhile.
        idleInputs();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 31'h2A0; req_len = 4'd3;
        wr_valid = 1'b1; wr_data = 64'hAAAA_0000_AAAA_0001; wr_mask = 8'hFF;
        applyStimulus();
        idleInputs();
        wr_valid = 1'b1; wr_data = 64'hBBBB_0000_BBBB_0002; wr_mask = 8'h0F;
        applyStimulus();
        idleInputs();
        req_valid = 1'b1; req_len = 4'd1; req_addr = 31'h7C0;
        applyStimulus();
        idleInputs();
        wr_valid = 1'b1; wr_data = 64'hCCCC_0000_CCCC_0003; wr_mask = 8'hF0;
        applyStimulus();
        idleInputs();
        applyStimulus();
        returnCredits();

        // Credit exhaustion, credit pulse, and simultaneous accept with credit return.
        for (int i = 0; i < INIT_CREDITS; i++) readReq(31'h400 + 31'(i * 8), 1);
        idleInputs();
        req_valid = 1'b1; req_addr = 31'h500; req_len = 4'd1;
        applyStimulus();
        fsabo_credit = 1'b1; applyStimulus();
        fsabo_credit = 1'b0; applyStimulus();
        fsabo_credit = 1'b1; applyStimulus();
        fsabo_credit = 1'b1; applyStimulus();
        fsabo_credit = 1'b0; applyStimulus();
        applyStimulus();
        for (int i = 0; i < 7; i++) sendBeat(TB_DID, 64'hE000 + 64'(i));
        returnCredits();

        // Two outstanding reads with foreign-DID beats interleaved.
        readReq(31'h600, 2);
        readReq(31'h640, 1);
        sendBeat(TB_DID, 64'h1111);
        sendBeat(OTHER_DID, 64'h9999);
        sendBeat(TB_DID, 64'h2222);
        sendBeat(OTHER_DID, 64'h8888);
        sendBeat(TB_DID, 64'h3333);
        returnCredits();

        // Randomized traffic with a well-behaved responder.
        respQ.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            req_valid    = ($urandom_range(0, 3) != 0);
            req_write    = $urandom_range(0, 1) == 1;
            req_len      = fsab_len_t'($urandom_range(1, FSAB_LEN_MAX));
            req_addr     = (FSAB_ADDR_HI + 1)'($urandom);
            wr_valid     = ($urandom_range(0, 3) != 0);
            wr_data      = {$urandom, $urandom};
            wr_mask      = (FSAB_MASK_HI + 1)'($urandom);
            fsabo_credit = (pendCred > 0) && ($urandom_range(0, 2) == 0);
            fsabi_valid  = 1'b0;
            fsabi_did    = OTHER_DID;
            fsabi_data   = {$urandom, $urandom};
            if (respQ.size() > 0 && $urandom_range(0, 1) == 0) begin
                fsabi_valid = 1'b1;
                fsabi_did   = TB_DID;
                respQ[0]    = respQ[0] - 1;
                if (respQ[0] == 0) respQ.delete(0);
            end else if ($urandom_range(0, 7) == 0) begin
                fsabi_valid = 1'b1;
            end
            applyStimulus();
        end
        for (int i = 0; i < 400 && (respQ.size() > 0 || pendCred > 0 || inWrite); i++) begin
            idleInputs();
            wr_valid     = 1'b1;
            wr_data      = {$urandom, $urandom};
            fsabo_credit = (pendCred > 0);
            if (respQ.size() > 0) begin
                fsabi_valid = 1'b1;
                fsabi_did   = TB_DID;
                fsabi_data  = {$urandom, $urandom};
                respQ[0]    = respQ[0] - 1;
                if (respQ[0] == 0) respQ.delete(0);
            end
            applyStimulus();
        end
        checkOutput("drain_timeout", 256'(respQ.size() + pendCred + int'(inWrite)), '0);

        // Zero-length requests are dropped and flag an error.
        idleInputs();
        doReset();
        readReq(31'h800, 0);
        idleInputs();
        req_valid = 1'b1; req_write = 1'b1; req_len = 4'd0; wr_valid = 1'b1;
        applyStimulus();
        idleInputs();
        applyStimulus();

        // Return beat with nothing outstanding.
        doReset();
        sendBeat(TB_DID, 64'h5555);
        idleInputs();
        applyStimulus();

        // Credit return while already full.
        doReset();
        idleInputs();
        fsabo_credit = 1'b1;
        applyStimulus();

        // Reset mid-write with two data beats still owed, then credits are back to full.
        doReset();
        idleInputs();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 31'h900; req_len = 4'd3;
        wr_valid = 1'b1; wr_data = 64'h1234_5678_9ABC_DEF0; wr_mask = 8'h3C;
        applyStimulus();
        #3;
        doReset();
        for (int i = 0; i < INIT_CREDITS + 1; i++) readReq(31'hA00 + 31'(i * 8), 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
